systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Source side of the 3x3 systolic matrix multiplier datapath.
- Buffers operand matrices A and B, loaded element-by-element, then on start drives the six array edge inputs with the diagonal skew the array expects.
- Row r of A is delayed r cycles and column c of B is delayed c cycles, with zero padding.
- Issues an accumulator-clear pulse before streaming and signals done once all 9 PE results are final.

Parameters:
- data_width, 8, width of every A/B element and of each edge output.
- DRAIN_CYCLES, 3, zero-fed cycles after the last operand so the furthest PE (row 2, col 2) finishes accumulating.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_load_valid  in  1  write one matrix element this cycle.
- i_load_sel  in  1  0 = matrix A, 1 = matrix B.
- i_load_addr  in  4  row-major index 0..8 (addr = 3*row + col).
- i_load_data  in  data_width  element value.
- i_start  in  1  begin one multiply pass (sampled in IDLE only).
- o_busy  out  1  high from the cycle after start is accepted until o_done.
- o_done  out  1  one-cycle pulse; array outputs final and stable.
- o_acc_clr  out  1  one-cycle pulse; ORed with i_rst at the array to zero the accumulators.
- o_Cell_A1, o_Cell_A4, o_Cell_A7  out  data_width each  A row 0/1/2 into array column 0.
- o_Cell_B1, o_Cell_B2, o_Cell_B3  out  data_width each  B col 0/1/2 into array row 0.

Behaviour:
- Reset (async, active-high): state=IDLE, both 9-entry buffers cleared to 0, counters 0, all outputs 0.
- Storage:
  - Loads are accepted only in IDLE; a load with addr>8 is ignored.
  - Loads while busy are ignored; the buffers are not altered mid-pass.
  - Load and start in the same IDLE cycle: the load is written and the pass uses the new value.
- FSM: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE. All outputs are registered.
  - IDLE: o_busy=0. i_start=1 moves to CLEAR.
  - CLEAR (1 cycle): o_acc_clr=1, edges 0, o_busy=1.
  - STREAM (5 cycles, t=0..4), edge values during cycle t:
    - o_Cell_A1=A[0][t] for t in 0..2; o_Cell_A4=A[1][t-1] for t in 1..3; o_Cell_A7=A[2][t-2] for t in 2..4.
    - o_Cell_B1=B[t][0] for t in 0..2; o_Cell_B2=B[t-1][1] for t in 1..3; o_Cell_B3=B[t-2][2] for t in 2..4.
    - Any edge outside its window = 0.
  - DRAIN (DRAIN_CYCLES cycles): all edges 0, o_busy=1.
  - DONE (1 cycle): o_done=1 and o_busy=1 in that cycle; next state IDLE.
- Total pass length: start edge to o_done = 1+5+DRAIN_CYCLES+1 = 10 cycles at default.
- i_start while busy is ignored (no queueing). A new pass may start in the cycle after DONE.
- Reset mid-pass: immediate return to IDLE, outputs 0, buffers cleared. The clear uses i_rst, so array accumulators also clear.
- No arithmetic is done here. The counter is 3 bits, saturating within each state and reloaded on every transition.

Decomposition:
- systolic_pkg:
  - N=3.
  - Constants SEL_A=0, SEL_B=1.
  - STREAM_LEN = 2*N-1.
  - typedef enum feeder_state_t {IDLE, CLEAR, STREAM, DRAIN, DONE}.
- Sub-module systolic_matrix_buf: 9-entry data_width register file with async reset, one write port and nine parallel read taps. Instantiated twice (A and B).
- Skew selection is combinational in systolic_feeder from counter t and registered into the edge outputs.

Test Plan:
- Reset: assert i_rst mid-cycle -> all outputs 0 asynchronously; o_busy=0; buffers read 0.
- Edge stream: load A=1..9 and B=10..18 row-major, then pulse start. Expect o_acc_clr=1 at cycle 1. STREAM cycles t=0..4 give A1/A4/A7 = (1,0,0),(2,4,0),(3,5,7),(0,6,8),(0,0,9) and B1/B2/B3 = (10,0,0),(13,11,0),(16,14,12),(0,17,15),(0,0,18). o_done at cycle 10 after start.
- End-to-end with array: A=1..9, B=identity -> at o_done the array outputs 1..9. A=all 2, B=all 3 -> every cell = 18.
- Ignored events: start during STREAM, load during DRAIN, addr=12 load in IDLE -> no pass restart, buffers unchanged, timing identical to a clean pass.
- Same-cycle load+start: write A[0]=200 together with start -> first o_Cell_A1 value = 200.
- Back-to-back: start asserted in the cycle after o_done -> second pass begins with CLEAR; o_done spacing = 11 cycles.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants and FSM state type for the systolic feeder
package systolic_pkg;

  localparam int N          = 3;
  localparam int STREAM_LEN = 2 * N - 1;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/systolic_matrix_buf.sv
// rtl/systolic_matrix_buf.sv - 9-entry operand register file, one write port, all entries tapped
module systolic_matrix_buf
  import systolic_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [3:0]                       wr_addr,
  input  logic [data_width-1:0]            wr_data,
  output logic [N*N-1:0][data_width-1:0]   taps
);

  // Out-of-range addresses are dropped here so callers need not filter them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
    end else if (wr_en && (wr_addr < 4'(N * N))) begin
      taps[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - buffers A/B and streams them diagonally skewed into a 3x3 systolic array
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int data_width   = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load_valid,
  input  logic                  i_load_sel,
  input  logic [3:0]            i_load_addr,
  input  logic [data_width-1:0] i_load_data,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_acc_clr,
  output logic [data_width-1:0] o_Cell_A1,
  output logic [data_width-1:0] o_Cell_A4,
  output logic [data_width-1:0] o_Cell_A7,
  output logic [data_width-1:0] o_Cell_B1,
  output logic [data_width-1:0] o_Cell_B2,
  output logic [data_width-1:0] o_Cell_B3
);

  feeder_state_t state;
  logic [2:0]    cnt;

  logic [N*N-1:0][data_width-1:0] a_taps;
  logic [N*N-1:0][data_width-1:0] b_taps;

  logic [N-1:0][data_width-1:0] a_edge_q;
  logic [N-1:0][data_width-1:0] b_edge_q;
  logic [N-1:0][data_width-1:0] a_edge_nxt;
  logic [N-1:0][data_width-1:0] b_edge_nxt;
  logic [2:0]                   t_nxt;

  logic load_ok;
  assign load_ok = i_load_valid && (state == IDLE);

  systolic_matrix_buf #(.data_width(data_width)) u_buf_a (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (load_ok && (i_load_sel == SEL_A)),
    .wr_addr (i_load_addr),
    .wr_data (i_load_data),
    .taps    (a_taps)
  );

  systolic_matrix_buf #(.data_width(data_width)) u_buf_b (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (load_ok && (i_load_sel == SEL_B)),
    .wr_addr (i_load_addr),
    .wr_data (i_load_data),
    .taps    (b_taps)
  );

  // Edges are registered, so select for the stream step the next cycle will present.
  assign t_nxt = (state == STREAM) ? cnt + 3'd1 : 3'd0;

  always_comb begin
    a_edge_nxt = '0;
    b_edge_nxt = '0;
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(t_nxt) == r + k) begin
          a_edge_nxt[r] = a_taps[N*r + k];
          b_edge_nxt[r] = b_taps[N*k + r];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_acc_clr <= 1'b0;
      a_edge_q  <= '0;
      b_edge_q  <= '0;
    end else begin
      o_done    <= 1'b0;
      o_acc_clr <= 1'b0;
      a_edge_q  <= '0;
      b_edge_q  <= '0;
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (i_start) begin
            state     <= CLEAR;
            o_acc_clr <= 1'b1;
            o_busy    <= 1'b1;
          end
        end
        CLEAR: begin
          state    <= STREAM;
          cnt      <= 3'd0;
          a_edge_q <= a_edge_nxt;
          b_edge_q <= b_edge_nxt;
        end
        STREAM: begin
          if (cnt == 3'(STREAM_LEN - 1)) begin
            state <= DRAIN;
            cnt   <= 3'd0;
          end else begin
            cnt      <= cnt + 3'd1;
            a_edge_q <= a_edge_nxt;
            b_edge_q <= b_edge_nxt;
          end
        end
        DRAIN: begin
          if (cnt == 3'(DRAIN_CYCLES - 1)) begin
            state  <= DONE;
            cnt    <= 3'd0;
            o_done <= 1'b1;
          end else if (cnt != 3'd7) begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          cnt    <= 3'd0;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          cnt    <= 3'd0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_Cell_A1 = a_edge_q[0];
  assign o_Cell_A4 = a_edge_q[1];
  assign o_Cell_A7 = a_edge_q[2];
  assign o_Cell_B1 = b_edge_q[0];
  assign o_Cell_B2 = b_edge_q[1];
  assign o_Cell_B3 = b_edge_q[2];

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - randomized self-checking bench for systolic_feeder with a matrix-product array model
module tb_systolic_feeder;

  logic       i_clk;
  logic       i_rst;
  logic       i_load_valid;
  logic       i_load_sel;
  logic [3:0] i_load_addr;
  logic [7:0] i_load_data;
  logic       i_start;
  logic       o_busy, o_done, o_acc_clr;
  logic [7:0] o_Cell_A1, o_Cell_A4, o_Cell_A7, o_Cell_B1, o_Cell_B2, o_Cell_B3;

  systolic_feeder #(.data_width(8), .DRAIN_CYCLES(3)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load_valid (i_load_valid),
    .i_load_sel   (i_load_sel),
    .i_load_addr  (i_load_addr),
    .i_load_data  (i_load_data),
    .i_start      (i_start),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_acc_clr    (o_acc_clr),
    .o_Cell_A1    (o_Cell_A1),
    .o_Cell_A4    (o_Cell_A4),
    .o_Cell_A7    (o_Cell_A7),
    .o_Cell_B1    (o_Cell_B1),
    .o_Cell_B2    (o_Cell_B2),
    .o_Cell_B3    (o_Cell_B3)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int last_done = 0;

  int ma[9];
  int mb[9];
  int ah[3][16];
  int bh[3][16];

  logic [7:0] a_out[3];
  logic [7:0] b_out[3];
  assign a_out[0] = o_Cell_A1;
  assign a_out[1] = o_Cell_A4;
  assign a_out[2] = o_Cell_A7;
  assign b_out[0] = o_Cell_B1;
  assign b_out[1] = o_Cell_B2;
  assign b_out[2] = o_Cell_B3;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Row r of A enters r cycles late; column c of B enters c cycles late.
  function automatic int exp_a(int r, int t);
    return (t >= r && t - r <= 2) ? ma[3*r + (t - r)] : 0;
  endfunction

  function automatic int exp_b(int c, int t);
    return (t >= c && t - c <= 2) ? mb[3*(t - c) + c] : 0;
  endfunction

  task automatic load(input logic sel, input int addr, input int data);
    i_load_valid = 1'b1;
    i_load_sel   = sel;
    i_load_addr  = 4'(addr);
    i_load_data  = 8'(data);
    if (addr <= 8) begin
      if (sel) mb[addr] = data & 255;
      else     ma[addr] = data & 255;
    end
    @(negedge i_clk);
    i_load_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 9; i++) load(1'b0, i, ma[i]);
    for (int i = 0; i < 9; i++) load(1'b1, i, mb[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_done"}, o_done, 0);
    check_eq({tag, "_clr"},  o_acc_clr, 0);
    for (int e = 0; e < 3; e++) begin
      check_eq({tag, "_a"}, a_out[e], 0);
      check_eq({tag, "_b"}, b_out[e], 0);
    end
  endtask

  // Entered at a negedge with the DUT idle; leaves at the negedge where it is idle again.
  task automatic run_pass(input string tag, input bit noise, input bit same_ld, input int sl_data,
                          input bit chk_gap);
    int t;
    int acc;
    int ref_c;
    for (int e = 0; e < 3; e++)
      for (int k = 0; k < 16; k++) begin ah[e][k] = 0; bh[e][k] = 0; end
    if (same_ld) begin
      i_load_valid = 1'b1; i_load_sel = 1'b0; i_load_addr = 4'd0; i_load_data = 8'(sl_data);
      ma[0] = sl_data & 255;
    end
    i_start = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      i_load_valid = 1'b0;
      t = j - 2;
      check_eq({tag, "_busy"}, o_busy, (j <= 10) ? 1 : 0);
      check_eq({tag, "_clr"},  o_acc_clr, (j == 1) ? 1 : 0);
      check_eq({tag, "_done"}, o_done, (j == 10) ? 1 : 0);
      for (int e = 0; e < 3; e++) begin
        check_eq({tag, "_edgeA"}, a_out[e], (t >= 0) ? exp_a(e, t) : 0);
        check_eq({tag, "_edgeB"}, b_out[e], (t >= 0) ? exp_b(e, t) : 0);
        if (t >= 0) begin ah[e][t] = a_out[e]; bh[e][t] = b_out[e]; end
      end
      if (o_done) begin
        if (chk_gap) check_eq({tag, "_done_gap"}, cyc - last_done, 11);
        last_done = cyc;
      end
      if (noise && j == 3) i_start = 1'b1;
      if (noise && j == 8) begin
        i_load_valid = 1'b1; i_load_sel = 1'b0; i_load_addr = 4'd0;
        i_load_data = 8'(~ma[0]);
      end
    end
    // Output-stationary array: PE(r,c) sees A row r delayed c and B column c delayed r.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        acc = 0;
        for (int k = 0; k < 16; k++)
          if (k - c >= 0 && k - r >= 0) acc += ah[r][k-c] * bh[c][k-r];
        ref_c = 0;
        for (int k = 0; k < 3; k++) ref_c += ma[3*r + k] * mb[3*k + c];
        check_eq({tag, "_pe"}, acc, ref_c);
      end
  endtask

  initial begin
    i_rst = 1'b1; i_load_valid = 1'b0; i_load_sel = 1'b0; i_load_addr = 4'd0;
    i_load_data = 8'd0; i_start = 1'b0;
    for (int i = 0; i < 9; i++) begin ma[i] = 0; mb[i] = 0; end
    repeat (2) @(negedge i_clk);
    check_all_zero("reset");
    i_rst = 1'b0;
    @(negedge i_clk);

    // Buffers come out of reset zeroed.
    run_pass("zero_buf", 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 9; i++) begin ma[i] = i + 1; mb[i] = i + 10; end
    load_all();
    run_pass("seq", 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 9; i++) mb[i] = (i % 4 == 0) ? 1 : 0;
    load_all();
    run_pass("ident", 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 9; i++) begin ma[i] = 2; mb[i] = 3; end
    load_all();
    run_pass("const", 1'b0, 1'b0, 0, 1'b0);

    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 18; i++) begin
        if ($urandom_range(0, 3) == 0) load($urandom_range(0, 1), $urandom_range(9, 15), $urandom_range(0, 255));
        load(i >= 9, i % 9, $urandom_range(0, 255));
      end
      run_pass("rand", 1'b0, 1'b0, 0, 1'b0);
    end

    load(1'b0, 12, 77);
    run_pass("noise", 1'b1, 1'b0, 0, 1'b0);
    run_pass("after_noise", 1'b0, 1'b0, 0, 1'b0);

    run_pass("same_ld", 1'b0, 1'b1, 200, 1'b0);
    check_eq("same_ld_a0", ah[0][0], 200);

    run_pass("b2b_first", 1'b0, 1'b0, 0, 1'b0);
    run_pass("b2b_second", 1'b0, 1'b0, 0, 1'b1);

    // Asynchronous reset in the middle of a stream.
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    check_eq("midrst_pre_busy", o_busy, 1);
    #2 i_rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 9; i++) begin ma[i] = 0; mb[i] = 0; end
    @(negedge i_clk);
    run_pass("post_rst", 1'b0, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
